// File: rtl/ex_lane_pkg.sv
// Shared types and helpers for the multi-lane execute stage and its shared divider.
package ex_lane_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_e;

  localparam int DEF_DATA_W = 32;
  localparam int CNT_W      = $clog2(DEF_DATA_W);
  localparam int MAX_LANES  = 4;
  localparam int LANE_IDX_W = 2;

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic logic [LANE_IDX_W-1:0] lowest_set(input logic [MAX_LANES-1:0] mask);
    lowest_set = '0;
    for (int i = MAX_LANES-1; i >= 0; i--)
      if (mask[i]) lowest_set = LANE_IDX_W'(i);
  endfunction

endpackage

// File: rtl/ex_iter_div.sv
// Unsigned restoring radix-2 divider: one quotient bit per cycle, DATA_W cycles per divide.
module ex_iter_div #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              abort,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              div_zero,
  output logic              done
);

  localparam int CNT_BITS = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [DATA_W-1:0]   acc;
  logic [DATA_W-1:0]   rem;
  logic [DATA_W-1:0]   dsr;
  logic [CNT_BITS-1:0] cnt;
  logic                running;

  logic [DATA_W:0] rem_shift;
  logic [DATA_W:0] diff;
  logic            take;

  assign rem_shift = {rem, acc[DATA_W-1]};
  assign diff      = rem_shift - {1'b0, dsr};
  assign take      = ~diff[DATA_W];
  assign done      = running && (cnt == CNT_BITS'(DATA_W-1));

  // A zero divisor makes every step "take", so the remainder already ends up
  // equal to the dividend; only the quotient is forced explicitly.
  assign div_zero  = (dsr == '0);
  assign quotient  = div_zero ? '1 : acc;
  assign remainder = rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      rem     <= '0;
      dsr     <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (abort) begin
      running <= 1'b0;
    end else if (start) begin
      acc     <= dividend;
      rem     <= '0;
      dsr     <= divisor;
      cnt     <= '0;
      running <= 1'b1;
    end else if (running) begin
      rem     <= take ? diff[DATA_W-1:0] : rem_shift[DATA_W-1:0];
      acc     <= (acc << 1) | DATA_W'(take);
      cnt     <= cnt + 1'b1;
      if (done) running <= 1'b0;
    end
  end

endmodule

// File: rtl/ex_lane_stage.sv
// Multi-lane EX pipeline slot: one group register, group-wide handshake, and a
// shared iterative divider that serves divide lanes in ascending lane order.
module ex_lane_stage
  import ex_lane_pkg::*;
#(
  parameter int LANES     = 2,
  parameter int DATA_W    = 32,
  parameter int PAYLOAD_W = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic [LANES-1:0]           in_valid_i,
  input  logic [LANES*PAYLOAD_W-1:0] in_payload_i,
  input  logic [LANES-1:0]           in_div_en_i,
  input  logic [LANES-1:0]           in_div_signed_i,
  input  logic [LANES*DATA_W-1:0]    in_dividend_i,
  input  logic [LANES*DATA_W-1:0]    in_divisor_i,
  output logic                       now_allowin_o,
  input  logic                       next_allowin_i,
  output logic [LANES-1:0]           out_valid_o,
  output logic [LANES*PAYLOAD_W-1:0] out_payload_o,
  output logic [LANES*DATA_W-1:0]    out_quotient_o,
  output logic [LANES*DATA_W-1:0]    out_remainder_o,
  output logic                       busy_o
);

  logic [LANES-1:0]                 stage_valid, pending, sgn;
  logic [LANES-1:0][PAYLOAD_W-1:0]  payload, in_pl;
  logic [LANES-1:0][DATA_W-1:0]     dvd, dvs, quot, rem, in_dvd, in_dvs;

  div_state_e              state, state_nx;
  logic [LANE_IDX_W-1:0]   sel, pick;
  logic                    ready_go, capture, div_start, div_wr, div_done, div_zero;

  logic [DATA_W-1:0] st_dvd, st_dvs, st_a, st_b;
  logic              st_sgn;
  logic [DATA_W-1:0] fx_dvd, fx_dvs, fx_q, fx_r, dq, dr;
  logic              fx_sgn, neg_q, neg_r;

  assign in_pl  = in_payload_i;
  assign in_dvd = in_dividend_i;
  assign in_dvs = in_divisor_i;

  assign ready_go      = ~|pending && (state == IDLE);
  assign now_allowin_o = ~|stage_valid || (ready_go && next_allowin_i);
  assign capture       = now_allowin_o && ~flush_i;
  assign out_valid_o   = stage_valid & {LANES{ready_go && ~flush_i}};
  assign busy_o        = (state != IDLE);
  assign pick          = lowest_set(MAX_LANES'(pending));

  assign out_payload_o   = payload;
  assign out_quotient_o  = quot;
  assign out_remainder_o = rem;

  always_comb begin
    state_nx  = state;
    div_start = 1'b0;
    div_wr    = 1'b0;
    if (flush_i) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: if (|pending) begin
          state_nx  = RUN;
          div_start = 1'b1;
        end
        RUN:  if (div_done) state_nx = DONE;
        DONE: begin
          state_nx = IDLE;
          div_wr   = 1'b1;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Operand mux for the lane being started and for the lane being retired.
  always_comb begin
    st_dvd = '0;
    st_dvs = '0;
    st_sgn = 1'b0;
    fx_dvd = '0;
    fx_dvs = '0;
    fx_sgn = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      if (pick == LANE_IDX_W'(l)) begin
        st_dvd = dvd[l];
        st_dvs = dvs[l];
        st_sgn = sgn[l];
      end
      if (sel == LANE_IDX_W'(l)) begin
        fx_dvd = dvd[l];
        fx_dvs = dvs[l];
        fx_sgn = sgn[l];
      end
    end
  end

  assign st_a = (st_sgn && st_dvd[DATA_W-1]) ? -st_dvd : st_dvd;
  assign st_b = (st_sgn && st_dvs[DATA_W-1]) ? -st_dvs : st_dvs;

  // Divide-by-zero keeps the all-ones quotient; the remainder still takes the
  // dividend's sign, which restores the original dividend.
  assign neg_q = fx_sgn && (fx_dvd[DATA_W-1] ^ fx_dvs[DATA_W-1]) && ~div_zero;
  assign neg_r = fx_sgn && fx_dvd[DATA_W-1];
  assign fx_q  = neg_q ? -dq : dq;
  assign fx_r  = neg_r ? -dr : dr;

  ex_iter_div #(.DATA_W(DATA_W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .abort     (flush_i),
    .start     (div_start),
    .dividend  (st_a),
    .divisor   (st_b),
    .quotient  (dq),
    .remainder (dr),
    .div_zero  (div_zero),
    .done      (div_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_valid <= '0;
      pending     <= '0;
      sgn         <= '0;
      payload     <= '0;
      dvd         <= '0;
      dvs         <= '0;
      quot        <= '0;
      rem         <= '0;
      sel         <= '0;
    end else if (flush_i) begin
      stage_valid <= '0;
      pending     <= '0;
    end else begin
      if (capture) begin
        stage_valid <= in_valid_i;
        pending     <= in_valid_i & in_div_en_i;
        sgn         <= in_div_signed_i;
        payload     <= in_pl;
        dvd         <= in_dvd;
        dvs         <= in_dvs;
        quot        <= '0;
        rem         <= '0;
      end else if (div_wr) begin
        for (int l = 0; l < LANES; l++) begin
          if (sel == LANE_IDX_W'(l)) begin
            pending[l] <= 1'b0;
            quot[l]    <= fx_q;
            rem[l]     <= fx_r;
          end
        end
      end
      if (div_start) sel <= pick;
    end
  end

endmodule

// File: doc/ex_lane_stage.md
Name: ex_lane_stage

Overview:
- Parametrised multi-lane execute-stage slot for the in-order superscalar pipeline. It sits between the ID stage and the MEM stage.
- Holds one issue group of LANES instructions in a single pipeline register with one group-wide handshake.
- Any lane may request a divide. A single shared iterative divider serves the requesting lanes in ascending lane order.
- The group is released to MEM only after all its divides finish. An exception flush aborts the group and the divider.

Parameters:
LANES, 2, issue width (number of lanes), 1..4
DATA_W, 32, divide operand/result width
PAYLOAD_W, 64, opaque per-lane payload carried ID->MEM unchanged

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
flush_i  in  1  exception flush
in_valid_i  in  LANES  per-lane valid from ID
in_payload_i  in  LANES*PAYLOAD_W  per-lane payload, lane i at [i*PAYLOAD_W +: PAYLOAD_W]
in_div_en_i  in  LANES  lane requests divide
in_div_signed_i  in  LANES  1=signed divide
in_dividend_i  in  LANES*DATA_W  per-lane dividend
in_divisor_i  in  LANES*DATA_W  per-lane divisor
now_allowin_o  out  1  stage can accept a group this cycle
next_allowin_i  in  1  MEM accepts this cycle
out_valid_o  out  LANES  per-lane valid to MEM
out_payload_o  out  LANES*PAYLOAD_W  registered payload
out_quotient_o  out  LANES*DATA_W  per-lane quotient (0 for non-divide lanes)
out_remainder_o  out  LANES*DATA_W  per-lane remainder (0 for non-divide lanes)
busy_o  out  1  divider FSM not IDLE

Behaviour:
Reset (async, rst=1):
- stage_valid=0, pending=0, FSM=IDLE.
- Payload, quotient and remainder registers = 0.
- Outputs during reset: out_valid_o=0, busy_o=0, now_allowin_o=1.

Handshake:
- ready_go = (pending==0) && FSM==IDLE.
- now_allowin_o = ~|stage_valid || (ready_go && next_allowin_i).
- out_valid_o[i] = stage_valid[i] && ready_go && ~flush_i.

Capture:
- On a clk edge with now_allowin_o && ~flush_i, all lanes load together: stage_valid<=in_valid_i, payload, operands, signed flags.
- pending<=in_valid_i & in_div_en_i.
- Result registers of lanes with a pending divide clear to 0.
- If now_allowin_o && no input is valid, stage_valid becomes 0 (the bubble propagates).

Divider FSM (IDLE, RUN, DONE):
- IDLE: if pending!=0, select the lowest set lane k and load |dividend|, |divisor| as unsigned values; counter=0; go to RUN.
- RUN: one restoring radix-2 step per cycle. After DATA_W steps (counter==DATA_W-1 at the edge), go to DONE.
- DONE: apply sign fix, write lane k's quotient/remainder, clear pending[k], go to IDLE.

Timing:
- One divide lane: results and out_valid become visible exactly DATA_W+2 cycles after the capture edge (34 cycles for DATA_W=32).
- Each further divide lane adds DATA_W+2 cycles.
- A group with no divide lanes has ready_go=1 in the cycle after capture.

Arithmetic:
- Signed mode: quotient is negated when the operand signs differ; remainder takes the dividend's sign.
- Divisor==0: quotient = all ones, remainder = the dividend, same DATA_W+2 latency.
- Signed MIN/-1: quotient = MIN, remainder = 0.
- Unsigned mode: operands are used as-is.

Flush:
- flush_i forces out_valid_o=0 combinationally.
- At the next edge: stage_valid=0, pending=0, FSM=IDLE, and no capture occurs.
- A flush mid-RUN discards the partial result. Flush has priority over capture and DONE write.

Simultaneous events:
- Release to MEM and capture of the next group happen on the same edge (full throughput without divides).
- While stalled (ready_go=1, next_allowin_i=0), all registered outputs hold stable.

Decomposition:
- Package ex_lane_pkg: FSM state enum {IDLE, RUN, DONE}, CNT_W=$clog2(DATA_W), and a lowest-set-bit priority function for lane selection.
- Sub-module ex_iter_div: unsigned restoring divider with start/done, counter and divide-by-zero handling; parametrised by DATA_W.
- ex_lane_stage owns the group register, pending mask, lane select, sign fix and handshake.

Test Plan:
- Two lanes without divides, next_allowin_i=1 -> each group appears the cycle after capture; back-to-back groups are accepted every cycle.
- Lane 1 only: signed -7/2 -> quotient -3 (0xFFFFFFFD), remainder -1. out_valid=2'b11 exactly 34 cycles after capture; now_allowin_o=0 meanwhile.
- Both lanes divide: lane0 100/7, lane1 unsigned 0xFFFFFFFF/16 -> lane0 (14,2) at edge 34, lane1 (0x0FFFFFFF,15) at edge 68; out_valid rises only at 68.
- Edge cases: divisor 0 with dividend 5 -> (0xFFFFFFFF, 5); signed 0x80000000/-1 -> (0x80000000, 0).
- flush_i at RUN cycle 10 -> out_valid 0 that cycle; next cycle busy_o=0, stage empty, now_allowin_o=1; a new divide then completes in a fresh 34 cycles with a correct result.
- Result ready with next_allowin_i=0 for 5 cycles -> outputs stable and no new capture; capture and release happen on the edge where next_allowin_i rises. Assert rst mid-RUN -> all outputs at reset values immediately.
